// File: rtl/pmt_acq_ctrl.sv
// PMT acquisition controller: buffers ADC hit samples into frames and streams
// each frame (8-byte header + big-endian samples) over AXI-Stream.
module pmt_acq_ctrl #(
  parameter int MAX_SAMPLES = 64,
  parameter int TIMEOUT     = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  input  logic [15:0] n,
  input  logic [15:0] m,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [15:0] drop_count
);

  localparam int AW = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
  localparam int CW = $clog2(MAX_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(2 * MAX_SAMPLES + 9);

  typedef enum logic [1:0] {IDLE, FILL, HEADER, PAYLOAD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   cnt_after;
  logic [TW-1:0]   timer;
  logic            stop_pending;
  logic [BW-1:0]   bidx;
  logic [BW-1:0]   nb;
  logic [15:0]     last_idx;
  logic [7:0]      nxt_byte;
  logic            nxt_last;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic            hs;
  logic            fill_wr;
  logic            full_hit;
  logic            timeout_hit;
  logic            to_out;
  logic            hdr_done;
  logic            frame_done;
  logic            out_state;

  logic [15:0]     buf_mem [MAX_SAMPLES];
  logic [15:0]     smp;
  logic [15:0]     hdr_cnt;
  logic [15:0]     hdr_n;
  logic [15:0]     hdr_m;
  logic [7:0]      hdr_seq;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign busy        = (state != IDLE);
  assign out_state   = (state == HEADER) || (state == PAYLOAD);
  assign hs          = m_axis_tvalid && m_axis_tready;
  assign fill_wr     = (state == FILL) && adc_valid;
  assign cnt_inc     = count + CW'(1);
  assign cnt_after   = fill_wr ? cnt_inc : count;
  assign full_hit    = fill_wr && (cnt_inc == CW'(MAX_SAMPLES));
  assign timeout_hit = (state == FILL) && !adc_valid && (count != '0) &&
                       (timer == TW'(TIMEOUT - 1));
  assign to_out      = (state == FILL) &&
                       (full_hit || timeout_hit || (stop && (cnt_after != '0)));
  assign hdr_done    = (state == HEADER) && hs && (bidx == BW'(7));
  assign frame_done  = (state == PAYLOAD) && hs && m_axis_tlast;

  // Byte position that the next handshake loads into the output register.
  assign nb       = bidx + BW'(1);
  assign last_idx = {hdr_cnt[14:0], 1'b0} + 16'd7;
  assign nxt_last = (16'(nb) == last_idx);

  // Prefetch: sample 0 is read throughout HEADER; each later sample is read
  // while the low byte of the previous one is being loaded.
  assign rd_en   = (state == HEADER) ||
                   ((state == PAYLOAD) && hs && !m_axis_tlast && nb[0]);
  assign rd_addr = (state == HEADER) ? '0 : AW'((nb - BW'(7)) >> 1);

  // Select the next outgoing byte: header fields, then sample MSB/LSB.
  always_comb begin
    nxt_byte = smp[7:0];
    if (nb < BW'(8)) begin
      case (nb[2:0])
        3'd1:    nxt_byte = hdr_seq;
        3'd2:    nxt_byte = hdr_cnt[15:8];
        3'd3:    nxt_byte = hdr_cnt[7:0];
        3'd4:    nxt_byte = hdr_n[15:8];
        3'd5:    nxt_byte = hdr_n[7:0];
        3'd6:    nxt_byte = hdr_m[15:8];
        3'd7:    nxt_byte = hdr_m[7:0];
        default: nxt_byte = 8'hA5;
      endcase
    end else if (!nb[0]) begin
      nxt_byte = smp[15:8];
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = FILL;
      FILL:    if (to_out) state_nxt = HEADER;
               else if (stop) state_nxt = IDLE;
      HEADER:  if (hdr_done) state_nxt = PAYLOAD;
      PAYLOAD: if (frame_done) state_nxt = (stop_pending || stop) ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame bookkeeping: sample count, idle timer, stop request, sequence, drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      timer        <= '0;
      stop_pending <= 1'b0;
      seq          <= 8'd0;
      drop_count   <= 16'd0;
    end else begin
      if ((state == IDLE) && start) count <= '0;
      else if (frame_done)          count <= '0;
      else if (state == FILL)       count <= cnt_after;

      timer <= ((state == FILL) && !adc_valid && (count != '0) && !timeout_hit) ?
               timer + TW'(1) : '0;

      if (frame_done)
        stop_pending <= 1'b0;
      else if ((to_out && stop) || (out_state && stop))
        stop_pending <= 1'b1;

      if (frame_done) seq <= seq + 8'd1;

      if (out_state && adc_valid) drop_count <= sat_inc16(drop_count);
    end
  end

  // AXI-Stream output register: header byte 0 loads on entry, then advances per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      bidx          <= '0;
    end else if (to_out) begin
      m_axis_tdata  <= 8'hA5;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
      bidx          <= '0;
    end else if (hs) begin
      if (m_axis_tlast) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else begin
        m_axis_tdata <= nxt_byte;
        m_axis_tlast <= nxt_last;
        bidx         <= nb;
      end
    end
  end

  // Sample buffer, prefetch register and header snapshot (no reset needed).
  always_ff @(posedge clk) begin
    if (fill_wr) buf_mem[count[AW-1:0]] <= adc_data;
    if (rd_en)   smp <= buf_mem[rd_addr];
    if (to_out) begin
      hdr_cnt <= 16'(cnt_after);
      hdr_n   <= n;
      hdr_m   <= m;
      hdr_seq <= seq;
    end
  end

endmodule

// File: tb/tb_pmt_acq_ctrl.sv
// Directed bench for pmt_acq_ctrl (MAX_SAMPLES=4, TIMEOUT=8).
module tb_pmt_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = 16'd0;
  logic [15:0] n = 16'd0;
  logic [15:0] m = 16'd0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic [7:0]  seq;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;

  logic [15:0] smp_list[$];
  logic [7:0]  exp_b[$];
  logic [7:0]  got_b[$];
  logic        got_l[$];

  pmt_acq_ctrl #(.MAX_SAMPLES(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .adc_valid(adc_valid), .adc_data(adc_data), .n(n), .m(m),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .seq(seq), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] v);
    adc_valid = 1'b1;
    adc_data  = v;
    step();
    adc_valid = 1'b0;
    smp_list.push_back(v);
  endtask

  // Expected frame from header fields and the samples fed since the last build.
  task automatic build_exp(input logic [7:0] s);
    logic [15:0] c;
    c = 16'(smp_list.size());
    exp_b.delete();
    exp_b.push_back(8'hA5);    exp_b.push_back(s);
    exp_b.push_back(c[15:8]);  exp_b.push_back(c[7:0]);
    exp_b.push_back(n[15:8]);  exp_b.push_back(n[7:0]);
    exp_b.push_back(m[15:8]);  exp_b.push_back(m[7:0]);
    foreach (smp_list[i]) begin
      exp_b.push_back(smp_list[i][15:8]);
      exp_b.push_back(smp_list[i][7:0]);
    end
    smp_list.delete();
  endtask

  task automatic wait_tvalid(input int bound);
    int c;
    c = 0;
    while (!m_axis_tvalid && c < bound) begin
      step();
      c++;
    end
    chk("hdr_wait_tvalid", 32'(m_axis_tvalid), 32'(1));
  endtask

  // Drain one frame; optional random tready, drop pulses and a stop pulse.
  task automatic run_frame(input int nbytes, input bit rnd, input bit drops, input int stop_at);
    int cyc;
    bit stalled;
    logic [7:0] hd;
    logic hl;
    cyc = 0; stalled = 1'b0; hd = 8'd0; hl = 1'b0;
    got_b.delete(); got_l.delete();
    while (got_b.size() < nbytes && cyc < 400) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      adc_valid = drops && (cyc == 2 || cyc == 5 || cyc == 8);
      adc_data  = 16'hDEAD;
      stop      = (cyc == stop_at);
      if (stalled) begin
        chk("stall_tdata", 32'(m_axis_tdata), 32'(hd));
        chk("stall_tlast", 32'(m_axis_tlast), 32'(hl));
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata;
      hl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        got_b.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      step();
      cyc++;
    end
    adc_valid = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    chk("frame_len", 32'(got_b.size()), 32'(nbytes));
    if (!rnd) chk("no_bubble_cycles", 32'(cyc), 32'(nbytes));
    for (int i = 0; i < nbytes; i++) begin
      if (i < got_b.size()) begin
        chk($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
        chk($sformatf("tlast%0d", i), 32'(got_l[i]), 32'(i == nbytes - 1));
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
    chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_seq", 32'(seq), 32'(0));
    chk("rst_drop", 32'(drop_count), 32'(0));
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    step();

    // Full 4-sample frame, tready high
    n = 16'h0010; m = 16'h0020;
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", 32'(busy), 32'(1));
    feed(16'h0001); feed(16'h0002); feed(16'h0003); feed(16'h0004);
    chk("hdr_first_tvalid", 32'(m_axis_tvalid), 32'(1));
    build_exp(8'h00);
    run_frame(16, 1'b0, 1'b0, -1);
    chk("f1_seq", 32'(seq), 32'(1));
    chk("f1_busy", 32'(busy), 32'(1));
    chk("f1_tvalid_after", 32'(m_axis_tvalid), 32'(0));

    // Empty FILL never times out; then 2 samples flush after 8 idle cycles
    repeat (10) step();
    chk("empty_no_timeout", 32'(m_axis_tvalid), 32'(0));
    chk("empty_busy", 32'(busy), 32'(1));
    n = 16'h0102; m = 16'h0304;
    feed(16'h1234); feed(16'hABCD);
    repeat (7) step();
    chk("timeout_early", 32'(m_axis_tvalid), 32'(0));
    step();
    chk("timeout_hdr", 32'(m_axis_tvalid), 32'(1));
    chk("timeout_a5", 32'(m_axis_tdata), 32'hA5);
    build_exp(8'h01);
    run_frame(12, 1'b0, 1'b0, -1);
    chk("f2_seq", 32'(seq), 32'(2));

    // Random backpressure with 3 dropped samples during the frame
    n = 16'h5555; m = 16'hAAAA;
    feed(16'h0A0B); feed(16'h0C0D); feed(16'h0E0F); feed(16'h1011);
    build_exp(8'h02);
    run_frame(16, 1'b1, 1'b1, -1);
    chk("drop_count3", 32'(drop_count), 32'(3));
    chk("f3_seq", 32'(seq), 32'(3));

    // Next frame excludes dropped samples; stop mid-payload
    n = 16'h0000; m = 16'h0000;
    feed(16'h7777); feed(16'h8888);
    wait_tvalid(20);
    build_exp(8'h03);
    run_frame(12, 1'b0, 1'b0, 9);
    chk("stop_busy", 32'(busy), 32'(0));
    chk("stop_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("f4_seq", 32'(seq), 32'(4));
    repeat (3) step();
    chk("stop_stay_idle", 32'(busy), 32'(0));

    // IDLE behaviour and stop with empty FILL
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    chk("idle_no_drop", 32'(drop_count), 32'(3));
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'(0));
    start = 1'b1; step(); start = 1'b0;
    chk("restart_busy", 32'(busy), 32'(1));
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_empty_idle", 32'(busy), 32'(0));
    repeat (3) step();
    chk("stop_empty_noframe", 32'(m_axis_tvalid), 32'(0));

    // Reset while stalled
    n = 16'hFFFF; m = 16'h0000;
    start = 1'b1; step(); start = 1'b0;
    feed(16'hFFFF); feed(16'h0000); feed(16'h8001); feed(16'h7FFE);
    m_axis_tready = 1'b0;
    step(); step();
    chk("stall_tvalid", 32'(m_axis_tvalid), 32'(1));
    chk("stall_a5", 32'(m_axis_tdata), 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("arst_tlast", 32'(m_axis_tlast), 32'(0));
    chk("arst_tdata", 32'(m_axis_tdata), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_seq", 32'(seq), 32'(0));
    chk("arst_drop", 32'(drop_count), 32'(0));
    step();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    smp_list.delete();
    repeat (5) step();
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(0));
    start = 1'b1; step(); start = 1'b0;
    feed(16'hFFFF); feed(16'h0000); feed(16'h8001); feed(16'h7FFE);
    build_exp(8'h00);
    run_frame(16, 1'b0, 1'b0, -1);
    chk("f5_seq", 32'(seq), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmt_acq_ctrl.md
PMT_ACQ_CTRL -- requirements
Module: pmt_acq_ctrl

Interface
REQ-001 Parameter MAX_SAMPLES, default 64, meaning samples per full frame (range 1..1024).
REQ-002 Parameter TIMEOUT, default 125000, meaning idle clk cycles before a partial frame is flushed.
REQ-003 Port clk, input, 1, the single clock for all logic (125 MHz core clock).
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, single-cycle pulse that arms acquisition.
REQ-006 Port stop, input, 1, single-cycle pulse that ends acquisition after the current frame.
REQ-007 Port adc_valid, input, 1, qualifies adc_data (one hit sample per asserted cycle).
REQ-008 Port adc_data, input, 16, ADC hit sample.
REQ-009 Port n, input, 16, valid-hit counter from the ADC front end.
REQ-010 Port m, input, 16, active-window counter from the ADC front end.
REQ-011 Port m_axis_tdata, output, 8, frame byte to the UDP payload path.
REQ-012 Port m_axis_tvalid / m_axis_tready / m_axis_tlast, output/input/output, 1 each, AXI-Stream handshake.
REQ-013 Port busy, output, 1, high whenever state is not IDLE.
REQ-014 Port seq, output, 8, sequence number of the next frame to send.
REQ-015 Port drop_count, output, 16, saturating count of discarded samples.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, HEADER and PAYLOAD.
REQ-017 In IDLE: start=1 -> FILL next cycle; sample count and timer cleared. start outside IDLE is ignored. start and stop together in IDLE -> stay IDLE.
REQ-018 In FILL: each adc_valid cycle writes adc_data to buffer[count] and increments count; the write completing count=MAX_SAMPLES -> HEADER next cycle.
REQ-019 In FILL with count>0: timer increments on each cycle without adc_valid and clears on adc_valid; timer reaching TIMEOUT-1 -> HEADER next cycle. With count=0 the timer holds at 0.
REQ-020 stop in FILL: count>0 (including a sample written the same cycle) -> HEADER with stop_pending set; count=0 -> IDLE.
REQ-021 stop in HEADER/PAYLOAD: sets stop_pending; the current frame completes unchanged.
REQ-022 On the FILL->HEADER transition cycle, n, m, count and seq SHALL be latched into the header snapshot.
REQ-023 The header SHALL be 8 bytes in order: 0xA5, seq, count[15:8], count[7:0], n[15:8], n[7:0], m[15:8], m[7:0].
REQ-024 PAYLOAD SHALL emit 2*count bytes: samples in write order, each MSB first; m_axis_tlast=1 only on the final payload byte.
REQ-025 A byte advances only on tvalid&tready; while tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-026 With tready held high, the frame SHALL stream one byte per cycle with no bubbles from the first header byte to tlast (buffer read latency is hidden by prefetch).
REQ-027 tvalid SHALL assert in the first cycle of HEADER.
REQ-028 On the tlast handshake: seq increments (255 wraps to 0); count clears; next state is IDLE if stop_pending (which then clears), else FILL.
REQ-029 adc_valid in HEADER or PAYLOAD SHALL discard the sample and increment drop_count, saturating at 0xFFFF. adc_valid in IDLE is ignored and not counted.
REQ-030 drop_count and seq SHALL clear only on reset, never on start.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, seq=0, drop_count=0, count, timer and stop_pending=0. Buffer contents are don't-care.
REQ-033 A reset mid-frame SHALL drop tvalid immediately without emitting tlast; after release the block stays in IDLE until start.

Verification
REQ-034 MAX_SAMPLES=4, start, then 4 adc_valid samples 0x0001..0x0004, n=0x0010, m=0x0020, tready=1 -> 16 consecutive bytes A5 00 00 04 00 10 00 20 00 01 00 02 00 03 00 04, tlast on the 16th byte, seq=1, busy stays 1.
REQ-035 TIMEOUT=8, 2 samples then silence -> header count=0x0002 after exactly 8 idle cycles, 12-byte frame total.
REQ-036 tready toggled randomly during a frame -> byte sequence identical to the tready=1 case; tdata stable while stalled.
REQ-037 3 adc_valid pulses during HEADER/PAYLOAD -> drop_count=3; a following frame excludes those samples.
REQ-038 stop pulsed mid-PAYLOAD -> current frame completes with tlast, then IDLE, busy=0; stop with count=0 in FILL -> IDLE next cycle with no frame.
REQ-039 rst_n asserted while tvalid=1 and tready=0 -> tvalid=0 immediately, seq=0, drop_count=0; no output until the next start.
